mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Two-port round-robin arbiter/sequencer in front of the 4x1024x8 banked memory.
//  Accepts read/write commands from two requesters and serialises them onto the memory's
//  cen/rd/wr/add/din pins. Waits out the read latency, captures dout and returns it
//  with a per-port done pulse. Also sequences whole-array clear through the memory's rst pin.
// PARAMETERS
//  AW      12  address width (bits [11:10] bank, [9:0] word)
//  DW      8   data width
//  RD_LAT  2   clocks from memory rd issue to valid mem_dout
// PORTS
//  clk        in   1   single clock; all state on posedge
//  rst        in   1   synchronous, active-high reset
//  req0/req1  in   1   port request; held high until ack
//  we0/we1    in   1   1=write, 0=read; sampled at ack
//  addr0/1    in   AW  address; sampled at ack
//  wdata0/1   in   DW  write data; sampled at ack
//  clr_req    in   1   one-cycle pulse: request memory clear
//  ack        out  2   one-cycle pulse, bit n = port n command accepted
//  done       out  2   one-cycle pulse, bit n = port n command complete
//  rdata      out  DW  read data; valid while done[n] high for a read
//  busy       out  1   high in any state other than IDLE
//  mem_cen    out  1   memory chip enable, active low
//  mem_rd     out  1   memory read strobe
//  mem_wr     out  1   memory write strobe
//  mem_rst    out  1   memory clear strobe
//  mem_add    out  AW  memory address
//  mem_din    out  DW  memory write data
//  mem_dout   in   DW  memory read data
// BEHAVIOUR
//  Reset values: ack=0, done=0, rdata=0, busy=0, mem_cen=1, mem_rd/wr/rst=0,
//    mem_add=0, mem_din=0, state=IDLE, rr_last=1 (port 0 wins first tie).
//  States:
//    IDLE:  priority: pending clear > requests.
//           Clear pending -> CLEAR.
//           Else pick port: only one req -> that port; both -> port != rr_last.
//           Latch we/addr/wdata, pulse ack[n], set rr_last=n -> ISSUE.
//    ISSUE (1 clk): mem_cen=0, mem_add/mem_din = latched values.
//           Write: mem_wr=1 -> RESP.
//           Read: mem_rd=1, load cnt=RD_LAT -> WAIT.
//    WAIT:  mem_cen=0, mem_rd=0, cnt decrements each clk.
//           At cnt==1: rdata<=mem_dout -> RESP.
//    RESP (1 clk): done[n]=1, mem_cen=1 -> IDLE.
//    CLEAR (1 clk): mem_rst=1, mem_cen=1, clr_pending<=0 -> RESP-less return to IDLE.
//  Strobes are registered outputs; exactly one strobe per command.
//  Latency, req seen high in IDLE at edge N (ack visible after N):
//    write: done after edge N+2;
//    read:  done after edge N+2+RD_LAT.
//  clr_req pulse sets clr_pending in any state; clear runs at next IDLE.
//    A second pulse while pending is merged.
//  req dropped before ack: no transaction. req still high after done: new request,
//    arbitrated normally (other port wins if also requesting).
//  Address wrap: none; full AW passed through unmodified.
//  rst mid-operation: abort; no done pulse; outputs return to reset values next clk;
//    clr_pending cleared.
// TESTING
//  1. Reset: rst high 2 clk -> mem_cen=1, busy=0, ack=done=0.
//  2. Port0 write 0x0A5=0x3C, then port0 read 0x0A5 -> ack, done0 at N+2;
//     read done0 at N+4 with rdata=0x3C.
//  3. req0 and req1 both high, reads 0x000/0xC00 -> grants port0, port1, port0
//     alternating; no done on wrong port.
//  4. clr_req pulse coincident with req1 write -> mem_rst one clk first, then write.
//     Read any address after clear -> 0x00.
//  5. rst asserted during WAIT of a read -> no done, mem_cen=1 next clk;
//     new read completes normally.
//  6. Bank boundary 0x3FF vs 0x400 writes 0x11/0x22 -> readbacks distinct.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester, clear and memory-pin bundle for mem_arbiter
interface mem_arbiter_if #(
    parameter int AW = 12,
    parameter int DW = 8
);
    logic          req0, req1, we0, we1, clr_req;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic [1:0]    ack, done;
    logic [DW-1:0] rdata;
    logic          busy;
    logic          mem_cen, mem_rd, mem_wr, mem_rst;
    logic [AW-1:0] mem_add;
    logic [DW-1:0] mem_din, mem_dout;
    modport master (
        output req0, req1, we0, we1, clr_req, addr0, addr1, wdata0, wdata1, mem_dout,
        input  ack, done, rdata, busy, mem_cen, mem_rd, mem_wr, mem_rst, mem_add, mem_din
    );
    modport slave (
        input  req0, req1, we0, we1, clr_req, addr0, addr1, wdata0, wdata1, mem_dout,
        output ack, done, rdata, busy, mem_cen, mem_rd, mem_wr, mem_rst, mem_add, mem_din
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin sequencer for a banked memory with read latency and clear
module mem_arbiter #(
    parameter int AW = 12,
    parameter int DW = 8,
    parameter int RD_LAT = 2
) (
    input logic clk,
    input logic rst,
    mem_arbiter_if.slave bus
);
    localparam int CW = $clog2(RD_LAT + 1);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, CLEAR} state_t;
    state_t state, state_nx;
    logic rr_last, port, we, clr_pending, clr_go, any_req, gnt;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [CW-1:0] cnt;
    // a clear pulse arriving in the same cycle as a request still wins
    assign clr_go = clr_pending | bus.clr_req;
    assign any_req = bus.req0 | bus.req1;
    assign gnt = (bus.req0 & bus.req1) ? ~rr_last : bus.req1;
    assign bus.busy = state != IDLE;
    always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = clr_go ? CLEAR : any_req ? ISSUE : IDLE;
            ISSUE:   state_nx = we ? RESP : WAIT;
            WAIT:    state_nx = (cnt == CW'(1)) ? RESP : WAIT;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.ack <= '0;
            bus.done <= '0;
            bus.rdata <= '0;
            bus.mem_cen <= 1'b1;
            bus.mem_rd <= 1'b0;
            bus.mem_wr <= 1'b0;
            bus.mem_rst <= 1'b0;
            bus.mem_add <= '0;
            bus.mem_din <= '0;
            rr_last <= 1'b1;
            clr_pending <= 1'b0;
            port <= 1'b0;
            we <= 1'b0;
            addr <= '0;
            wdata <= '0;
            cnt <= '0;
        end else begin
            bus.ack <= '0;
            bus.done <= '0;
            bus.mem_rd <= 1'b0;
            bus.mem_wr <= 1'b0;
            bus.mem_rst <= 1'b0;
            clr_pending <= (state == CLEAR) ? bus.clr_req : clr_go;
            case (state)
                IDLE: if (!clr_go && any_req) begin
                    bus.ack <= gnt ? 2'b10 : 2'b01;
                    port <= gnt;
                    rr_last <= gnt;
                    we <= gnt ? bus.we1 : bus.we0;
                    addr <= gnt ? bus.addr1 : bus.addr0;
                    wdata <= gnt ? bus.wdata1 : bus.wdata0;
                end
                ISSUE: begin
                    bus.mem_cen <= 1'b0;
                    bus.mem_add <= addr;
                    bus.mem_din <= wdata;
                    bus.mem_wr <= we;
                    bus.mem_rd <= ~we;
                    cnt <= CW'(RD_LAT);
                end
                WAIT: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) bus.rdata <= bus.mem_dout;
                end
                RESP: begin
                    bus.done <= port ? 2'b10 : 2'b01;
                    bus.mem_cen <= 1'b1;
                end
                CLEAR: begin
                    bus.mem_rst <= 1'b1;
                    bus.mem_cen <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
